// File: rtl/branch_history_table.sv
// branch_history_table: bimodal/gshare table of saturating counters with global history and branch statistics
module branch_history_table #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6,
  parameter int MODE    = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             predict_o,
  output logic [GHR_W-1:0] ghr_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic [GHR_W-1:0] upd_ghr_i,
  input  logic             upd_taken_i,
  input  logic             upd_predict_i,
  input  logic             clear_i,
  output logic [31:0]      branch_cnt_o,
  output logic [31:0]      mispredict_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] table_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [CNT_W-1:0] cur, nxt;
  logic             unused_ok;
  // gshare folds the history into the low index bits; bimodal uses the PC alone
  assign lk_idx = lookup_pc_i[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(ghr_q) : '0);
  assign up_idx = upd_pc_i[IDX_W+1:2] ^ ((MODE != 0) ? IDX_W'(upd_ghr_i) : '0);
  assign predict_o = table_q[lk_idx][CNT_W-1];
  assign ghr_o = ghr_q;
  assign unused_ok = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};
  always_comb begin
    cur = table_q[up_idx];
    nxt = upd_taken_i ? ((cur == CNT_MAX) ? cur : cur + CNT_W'(1))
                      : ((cur == '0) ? cur : cur - CNT_W'(1));
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RST;
      ghr_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RST;
      ghr_q <= '0;
    end else if (upd_valid_i) begin
      table_q[up_idx] <= nxt;
      ghr_q <= GHR_W'({ghr_q, upd_taken_i});
    end
  end
  // statistics survive a table clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_o <= '0;
      mispredict_cnt_o <= '0;
    end else if (upd_valid_i && !clear_i) begin
      branch_cnt_o <= branch_cnt_o + 32'(branch_cnt_o != '1);
      mispredict_cnt_o <= mispredict_cnt_o + 32'((upd_taken_i != upd_predict_i) && (mispredict_cnt_o != '1));
    end
  end
endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table: directed vectors, expected values queued and compared by a negedge monitor
module tb_branch_history_table;
  localparam int P0 = 0, P1 = 1, G0 = 2, G1 = 3, B0 = 4, M0 = 5;
  logic        clk = 0, rst = 0;
  logic [31:0] lpc, upc;
  logic        uv, ut, up, clr;
  logic [5:0]  ugh;
  logic        p0, p1;
  logic [5:0]  g0, g1;
  logic [31:0] b0, m0, b1, m1;
  int          n_pass = 0, n_tot = 0;
  int          exp_b = 0, exp_m = 0;
  logic [5:0]  egh = '0;
  int          kq[$];
  logic [31:0] eq[$];
  string       nq[$];
  always #5 clk = ~clk;
  branch_history_table #(.MODE(0)) u0 (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lpc), .predict_o(p0), .ghr_o(g0),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ugh), .upd_taken_i(ut),
    .upd_predict_i(up), .clear_i(clr), .branch_cnt_o(b0), .mispredict_cnt_o(m0));
  branch_history_table #(.MODE(1)) u1 (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lpc), .predict_o(p1), .ghr_o(g1),
    .upd_valid_i(uv), .upd_pc_i(upc), .upd_ghr_i(ugh), .upd_taken_i(ut),
    .upd_predict_i(up), .clear_i(clr), .branch_cnt_o(b1), .mispredict_cnt_o(m1));
  function automatic logic [31:0] act(int k);
    case (k)
      P0: return {31'b0, p0};
      P1: return {31'b0, p1};
      G0: return {26'b0, g0};
      G1: return {26'b0, g1};
      B0: return b0;
      default: return m0;
    endcase
  endfunction
  always @(negedge clk) begin
    while (kq.size() > 0) begin
      int k;
      logic [31:0] e, a;
      string n;
      k = kq.pop_front();
      e = eq.pop_front();
      n = nq.pop_front();
      a = act(k);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  end
  task automatic chk(int k, logic [31:0] e, string n);
    kq.push_back(k);
    eq.push_back(e);
    nq.push_back(n);
  endtask
  task automatic now_chk(int k, logic [31:0] e, string n);
    logic [31:0] a;
    a = act(k);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_upd(logic [31:0] pc, logic t, logic p);
    upc = pc;
    ut = t;
    up = p;
    uv = 1;
    exp_b++;
    if (t != p) exp_m++;
    egh = {egh[4:0], t};
  endtask
  task automatic upd(logic [31:0] pc, logic t, logic p);
    set_upd(pc, t, p);
    cyc();
    uv = 0;
  endtask
  initial begin
    uv = 0; ut = 0; up = 0; clr = 0; ugh = '0; upc = '0; lpc = 32'h40;
    cyc(); cyc();
    now_chk(P0, 1, "rst_predict"); now_chk(P1, 1, "rst_predict_gs");
    now_chk(B0, 0, "rst_bcnt"); now_chk(M0, 0, "rst_mcnt"); now_chk(G0, 0, "rst_ghr");
    cyc();
    rst = 1;
    upd(32'h40, 1, 1); upd(32'h40, 1, 1); upd(32'h40, 1, 1);
    chk(P0, 1, "sat_hi"); chk(B0, 3, "bcnt_3"); chk(M0, 0, "mcnt_0");
    cyc();
    repeat (4) upd(32'h40, 0, 1);
    chk(P0, 0, "sat_lo"); chk(M0, 4, "mcnt_4");
    cyc();
    upd(32'h40, 1, 0);
    chk(P0, 0, "no_wrap");
    cyc();
    upd(32'h40, 1, 0);
    chk(P0, 1, "inc_to_2");
    cyc();
    set_upd(32'h40, 0, 1);
    chk(P0, 1, "bypass_old");
    cyc();
    uv = 0;
    chk(P0, 0, "bypass_new");
    cyc();
    upd(32'h100, 0, 1); upd(32'h100, 0, 1);
    lpc = 32'h0;
    chk(P0, 0, "alias_hit");
    cyc();
    lpc = 32'h4;
    chk(P0, 1, "alias_miss");
    chk(B0, exp_b, "bcnt"); chk(M0, exp_m, "mcnt"); chk(G0, egh, "ghr_bimodal");
    cyc();
    clr = 1; uv = 1; upc = 32'h0; ut = 0; up = 1;
    cyc();
    clr = 0; uv = 0; egh = '0;
    lpc = 32'h0;
    chk(P0, 1, "clr_pred0"); chk(G0, 0, "clr_ghr0"); chk(G1, 0, "clr_ghr1");
    chk(B0, exp_b, "clr_bcnt"); chk(M0, exp_m, "clr_mcnt");
    cyc();
    lpc = 32'h40;
    chk(P0, 1, "clr_pred40");
    cyc();
    upd(32'h80, 1, 1); upd(32'h80, 0, 1); upd(32'h80, 1, 1);
    chk(G1, 6'b000101, "gs_ghr"); chk(G0, 6'b000101, "ghr_tnt");
    chk(P1, 1, "gs_pre");
    cyc();
    ugh = 6'b000101;
    upd(32'h40, 0, 1);
    ugh = '0;
    lpc = 32'h7C;
    chk(P1, 0, "gs_e21");
    cyc();
    lpc = 32'h68;
    chk(P1, 1, "gs_e16");
    chk(G1, 6'h0A, "gs_ghr2");
    cyc();
    set_upd(32'h40, 1, 0);
    cyc();
    #2;
    rst = 0;
    #1;
    exp_b = 0; exp_m = 0; egh = '0;
    lpc = 32'h40;
    #0;
    now_chk(P0, 1, "arst_pred"); now_chk(B0, 0, "arst_bcnt"); now_chk(M0, 0, "arst_mcnt");
    now_chk(G1, 0, "arst_ghr");
    cyc();
    #2;
    rst = 1;
    set_upd(32'h40, 0, 1);
    chk(B0, 0, "rel_no_early"); chk(P0, 1, "rel_pred");
    cyc();
    uv = 0;
    chk(B0, 1, "rel_bcnt"); chk(M0, 1, "rel_mcnt"); chk(P0, 0, "rel_first_upd");
    chk(G0, 0, "rel_ghr");
    cyc();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 Parameter ENTRIES, default 64, meaning: number of counter entries, power of two, 4..1024.
REQ-002 Parameter CNT_W, default 2, meaning: saturating counter width, 1..4.
REQ-003 Parameter GHR_W, default 6, meaning: global history length, 1..log2(ENTRIES).
REQ-004 Parameter MODE, default 0, meaning: 0 = bimodal, 1 = gshare.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous, active-low.
REQ-007 lookup_pc_i  input  32  PC of the branch in ID.
REQ-008 predict_o  output  1  1 = predict taken.
REQ-009 ghr_o  output  GHR_W  current global history; the pipeline carries it with the branch.
REQ-010 upd_valid_i  input  1  a branch resolves in EX this cycle.
REQ-011 upd_pc_i  input  32  PC of the resolving branch.
REQ-012 upd_ghr_i  input  GHR_W  ghr_o snapshot taken when that branch was looked up.
REQ-013 upd_taken_i  input  1  actual outcome.
REQ-014 upd_predict_i  input  1  prediction originally issued for that branch.
REQ-015 clear_i  input  1  synchronous table and history clear.
REQ-016 branch_cnt_o  output  32  count of resolved branches.
REQ-017 mispredict_cnt_o  output  32  count of mispredictions.

Function
REQ-018 IDX_W = log2(ENTRIES); the base index is pc[IDX_W+1:2].
REQ-019 When MODE=0, the index is the base index.
REQ-020 When MODE=1, the index is the base index XOR the history zero-extended to IDX_W bits.
REQ-021 Lookup uses ghr_o; update uses upd_ghr_i.
REQ-022 predict_o is combinational from lookup_pc_i and current state, with zero cycles of latency.
REQ-023 predict_o = MSB of the indexed counter.
REQ-024 When upd_valid_i=1, the counter at the update index increments if upd_taken_i=1 and decrements otherwise.
REQ-025 Counters saturate at 2^CNT_W-1 and at 0; they never wrap.
REQ-026 When upd_valid_i=1, the history shifts left by one and upd_taken_i enters at the LSB.
REQ-027 The history is updated non-speculatively, at resolution only.
REQ-028 When lookup and update hit the same index in the same cycle, predict_o shows the pre-update value; the new value is visible the next cycle.
REQ-029 When upd_valid_i=1, branch_cnt_o increments by 1.
REQ-030 When upd_valid_i=1 and upd_taken_i != upd_predict_i, mispredict_cnt_o increments by 1.
REQ-031 Both statistics counters saturate at 32'hFFFF_FFFF.
REQ-032 When upd_valid_i=0, no state changes, except as required by clear_i.
REQ-033 When clear_i=1, all counters are set to the reset value and the history is set to 0 at the next edge.
REQ-034 When clear_i=1, the statistics counters are not changed.
REQ-035 clear_i takes priority over a simultaneous update.
REQ-036 Update index bits above IDX_W+1 of the PC are ignored, so aliasing is permitted.
REQ-037 PC bits [1:0] are ignored.

Reset
REQ-038 While rst_i=0, every counter is held at 2^(CNT_W-1), weakly taken (2'b10 at default).
REQ-039 While rst_i=0, the history is held at 0, and branch_cnt_o and mispredict_cnt_o are held at 0.
REQ-040 While rst_i=0, predict_o = 1 for every PC.
REQ-041 Reset asserted mid-update discards that update; state is the reset state on release.
REQ-042 The first update is honoured on the first rising edge after rst_i rises.

Verification
REQ-043 Saturation, defaults, MODE=0, PC 0x40:
- Stimulus: release reset, then apply 3 updates with taken=1.
  -> counter[16]=3, predict_o=1.
- Stimulus: then apply 4 updates with taken=0.
  -> counter[16]=0, predict_o=0, no wrap.
REQ-044 Same-cycle bypass, counter 2:
- Stimulus: lookup and update (taken=0) of PC 0x40 in the same cycle.
  -> predict_o=1 that cycle, predict_o=0 the next cycle.
REQ-045 Aliasing, ENTRIES=64:
- Stimulus: update PC 0x100 with taken=0 twice.
  -> PC 0x0 (same index 0) predicts 0.
  -> PC 0x4 still predicts 1.
REQ-046 Gshare, MODE=1:
- Stimulus: outcomes T,N,T.
  -> ghr_o=6'b000101.
- Stimulus: update PC 0x40 with upd_ghr_i=6'b000101.
  -> entry 16^5=21 is modified; entry 16 is unchanged.
REQ-047 Statistics:
- Stimulus: 10 updates, of which 3 have taken != predict.
  -> branch_cnt_o=10, mispredict_cnt_o=3.
- Stimulus: clear_i pulse.
  -> counters still 10 and 3; all predict_o=1; ghr_o=0.
REQ-048 Asynchronous reset:
- Stimulus: drop rst_i between edges during an update burst.
  -> outputs reach reset values before the next edge.
  -> no update is applied after rst_i rises until the first edge.
